// File: rtl/conv_ctrl_pkg.sv
// Shared types and default geometry for the convolution frame controller.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DEF_IMG_W    = 64;
  localparam int unsigned DEF_IMG_H    = 64;
  localparam int unsigned DEF_PIPE_LAT = 3;
  localparam int unsigned DEF_CW       = 7;

  function automatic int unsigned frame_pix(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  localparam int unsigned FRAME_PIX = frame_pix(DEF_IMG_W, DEF_IMG_H);

endpackage

// File: rtl/lat_delay_line.sv
// Valid-bit delay line matching the fixed kernel pipeline latency; never stalls.
module lat_delay_line #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic empty
);

  logic [DEPTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      stage_q <= '0;
    end else begin
      stage_q <= (stage_q << 1) | DEPTH'(din);
    end
  end

  assign dout  = stage_q[DEPTH-1];
  assign empty = ~|stage_q;

endmodule

// File: rtl/conv_frame_ctrl.sv
// Raster window-read sequencer and result-write tracker for the 3x3 convolution datapath.
// Define CONV_CTRL_PERF_CNT_EN to build the saturating stall-cycle counter.
module conv_frame_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W    = DEF_IMG_W,
  parameter int unsigned IMG_H    = DEF_IMG_H,
  parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [CW-1:0] rd_row,
  output logic [CW-1:0] rd_col,
  output logic          wr_en,
  output logic [CW-1:0] wr_row,
  output logic [CW-1:0] wr_col,
  output logic [15:0]   stall_cycles
);

  localparam int unsigned   Total    = frame_pix(IMG_W, IMG_H);
  localparam int unsigned   NW       = $clog2(Total + 1);
  localparam logic [CW-1:0] ColMax   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] RowMax   = CW'(IMG_H - 1);
  localparam logic [NW-1:0] TotalCnt = NW'(Total);

  state_e        state_q;
  logic [CW-1:0] rd_row_q, rd_col_q;  // next window to issue
  logic [NW-1:0] wr_cnt_q;            // results that have entered the write register
  logic          issue, rd_last, wr_last;
  logic          dl_out, dl_empty;

  always_comb begin
    issue   = (state_q == StRun) && !stall && !abort;
    rd_last = (rd_row_q == RowMax) && (rd_col_q == ColMax);
    wr_last = (wr_row == RowMax) && (wr_col == ColMax);
  end

  lat_delay_line #(
    .DEPTH(PIPE_LAT)
  ) u_lat_delay_line (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (abort),
    .din  (issue),
    .dout (dl_out),
    .empty(dl_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_row   <= '0;
      rd_col   <= '0;
      wr_en    <= 1'b0;
      wr_row   <= '0;
      wr_col   <= '0;
      rd_row_q <= '0;
      rd_col_q <= '0;
      wr_cnt_q <= '0;
    end else if (abort) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
    end else begin
      rd_en <= issue;
      wr_en <= dl_out;
      done  <= 1'b0;
      if (dl_out) begin
        wr_cnt_q <= wr_cnt_q + NW'(1);
      end
      // Write coordinates shown with wr_en step after each write, stopping at the last pixel.
      if (wr_en && !wr_last) begin
        if (wr_col == ColMax) begin
          wr_col <= '0;
          wr_row <= wr_row + CW'(1);
        end else begin
          wr_col <= wr_col + CW'(1);
        end
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StRun;
            busy     <= 1'b1;
            rd_row_q <= '0;
            rd_col_q <= '0;
            wr_row   <= '0;
            wr_col   <= '0;
            wr_cnt_q <= '0;
          end
        end
        StRun: begin
          if (!stall) begin
            rd_row <= rd_row_q;
            rd_col <= rd_col_q;
            if (rd_last) begin
              state_q <= StDrain;
            end else if (rd_col_q == ColMax) begin
              rd_col_q <= '0;
              rd_row_q <= rd_row_q + CW'(1);
            end else begin
              rd_col_q <= rd_col_q + CW'(1);
            end
          end
        end
        StDrain: begin
          if (dl_empty && (wr_cnt_q == TotalCnt)) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef CONV_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StIdle) && start && !abort) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StRun) && stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Frame sequencer for the 66x66 zero-padded window memory that feeds the 3x3 convolution datapath.
- On a start handshake it issues one 3x3 window read per cycle for every output pixel of an IMG_H x IMG_W frame, in raster order.
- It tracks results through the fixed-latency kernel pipeline and drives write enables and write coordinates for the result store.
- It signals busy and done back to the top-level host FSM.

Parameters:
- IMG_W, 64, output pixels per row (window columns 0..IMG_W-1)
- IMG_H, 64, output rows
- PIPE_LAT, 3, cycles from a window read issue to its result being valid at the write port (>=1)
- CW, 7, coordinate width; must satisfy 2^CW > max(IMG_W, IMG_H)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  frame start request; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- stall  in  1  downstream backpressure; suppresses new read issue
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at frame completion
- rd_en  out  1  window read strobe to the memory
- rd_row  out  CW  window top-left row
- rd_col  out  CW  window top-left column
- wr_en  out  1  result write strobe
- wr_row  out  CW  result row
- wr_col  out  CW  result column
- stall_cycles  out  16  count of stalled RUN cycles (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a posedge): state=IDLE; delay line cleared; all outputs 0; rd/wr counters 0. Reset mid-frame discards in-flight results, and no wr_en or done follows.
- All outputs are registered.
- States:
  - IDLE -> RUN when start=1 (and abort=0). Counters clear on this transition.
  - RUN -> DRAIN in the cycle after the last window (IDLE_H-1, IMG_W-1) is issued.
  - DRAIN -> DONE when the delay line is empty and the write count equals IMG_W*IMG_H.
  - DONE -> IDLE unconditionally after one cycle.
- RUN:
  - Each cycle with stall=0: rd_en=1 and rd_row/rd_col hold the current read counters. The counters then advance: col+1, wrapping at IMG_W-1 to 0 with row+1.
  - stall=1: rd_en=0, counters hold.
- The kernel pipeline is not stallable. The valid delay line of length PIPE_LAT always shifts, so stalls become bubbles.
- wr_en equals the delay-line output. wr_row/wr_col come from write counters that advance on each wr_en, using the same raster rule. Because results stay in order, the coordinates of a result issued at cycle t appear with wr_en at cycle t+PIPE_LAT.
- busy=1 in RUN and DRAIN. done=1 only in the DONE cycle.
- start while busy or in DONE is ignored, with no queuing.
- abort=1 has priority over everything except reset. From any state, the next cycle is IDLE, the delay line is cleared, rd_en/wr_en=0, and done is not pulsed.
- Simultaneous start and abort in IDLE: abort wins, and the block stays in IDLE.
- Counters never exceed IMG_W-1 / IMG_H-1. No wrap past the last row.

Optional Feature:
- Macro: CONV_CTRL_PERF_CNT_EN.
- Defined: stall_cycles increments on each RUN cycle with stall=1. It saturates at 16'hFFFF, clears on the IDLE->RUN transition, and holds its value after done.
- Undefined: the counter logic is absent, and stall_cycles is tied to 0.

Decomposition:
- Package conv_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - default IMG_W/IMG_H/PIPE_LAT localparams
  - the frame pixel-count constant
- Sub-module lat_delay_line: a PIPE_LAT-deep 1-bit shift register with synchronous clear. It provides the valid out and an empty flag (OR-reduction of the stages).

Test Plan:
- No stall, defaults: start pulse in IDLE -> 4096 consecutive rd_en cycles, first (0,0), then (0,63) followed by (1,0), last (63,63). The first wr_en comes 3 cycles after the first rd_en, with 4096 total. done pulses once, 1 cycle after the final wr_en (63,63). busy falls with done.
- Stall burst: stall=1 for 5 cycles after issue of (2,10) -> rd_en low for 5 cycles and the next issue is (2,11). wr_en shows a matching 5-cycle gap 3 cycles later. With the macro defined, stall_cycles=5 at done.
- Abort mid-frame at row 20 -> next cycle IDLE, busy=0, no further rd_en/wr_en, no done pulse. A subsequent start restarts at (0,0).
- Reset asserted in DRAIN with 2 results in flight -> all outputs 0 the next cycle, and no wr_en emerges.
- Start asserted during RUN, and start+abort together in IDLE -> ignored in both cases; rd sequence unaffected / block remains in IDLE.
- Small frame IMG_W=4, IMG_H=2, PIPE_LAT=1 -> 8 reads, each write 1 cycle behind its read, done at cycle 10 after the start sample.
